// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register bank.
// Register addresses map directly onto the PWM stage configuration inputs.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } spi_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with one delay flop for edge detection.
// Reset value matches the idle level of the line so reset never fakes an edge.
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~dly_q;
  assign fall_o  = ~level_o & dly_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Write-only SPI mode-0 target driving the PWM stage configuration registers.
// All SPI pins are synchronised and sampled in the clk domain.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  logic sclk_rise;
  logic copi_s;
  logic ncs_rise;
  logic ncs_fall;
  logic unused_sclk_lvl;
  logic unused_sclk_fall;
  logic unused_copi_rise;
  logic unused_copi_fall;
  logic unused_ncs_lvl;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sclk),
    .level_o(unused_sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (unused_sclk_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_copi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (copi),
    .level_o(copi_s),
    .rise_o (unused_copi_rise),
    .fall_o (unused_copi_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b1)
  ) u_ncs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ncs),
    .level_o(unused_ncs_lvl),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  // Ignore edges until the chains hold real pin values, so an
  // ncs already low at reset release cannot open a frame.
  logic [SW-1:0] settle_q;
  logic          ready;

  assign ready = (settle_q == SW'(SETTLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
    end else if (!ready) begin
      settle_q <= settle_q + 1'b1;
    end
  end

  spi_state_t  state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic        ovf_q,   ovf_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (ready && ncs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          if (cnt_q == 5'(FRAME_BITS)) begin
            ovf_d = 1'b1;
          end else begin
            shift_d = {shift_q[14:0], copi_s};
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  logic [6:0] addr;
  logic [7:0] data;
  logic       we;

  assign addr = shift_q[14:8];
  assign data = shift_q[7:0];
  assign we   = (state_q == COMMIT)
             && (cnt_q == 5'(FRAME_BITS))
             && !ovf_q
             && shift_q[15]
             && (32'(addr) < NUM_REGS);

  logic [7:0] out_lo_q, out_hi_q;
  logic [7:0] pwm_lo_q, pwm_hi_q;
  logic [7:0] duty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lo_q <= '0;
      out_hi_q <= '0;
      pwm_lo_q <= '0;
      pwm_hi_q <= '0;
      duty_q   <= '0;
    end else if (we) begin
      unique case (1'b1)
        (addr == ADDR_EN_OUT_LO): out_lo_q <= data;
        (addr == ADDR_EN_OUT_HI): out_hi_q <= data;
        (addr == ADDR_EN_PWM_LO): pwm_lo_q <= data;
        (addr == ADDR_EN_PWM_HI): pwm_hi_q <= data;
        (addr == ADDR_DUTY):      duty_q   <= data;
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised and directed bench for spi_reg_bank against a
// frame-level register model.
module tb_spi_reg_bank;

  localparam int H   = 4;
  localparam int GAP = 5;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] o0, o1, o2, o3, o4;

  logic [7:0] exp_q [5];
  int         checks = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  spi_reg_bank #(
    .SYNC_STAGES(2),
    .NUM_REGS   (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_reg_out_7_0 (o0),
    .en_reg_out_15_8(o1),
    .en_reg_pwm_7_0 (o2),
    .en_reg_pwm_15_8(o3),
    .pwm_duty_cycle (o4)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0: return o0;
      1: return o1;
      2: return o2;
      3: return o3;
      4: return o4;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_r%0d", tag, i), dut_reg(i), exp_q[i]);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A frame only commits if exactly 16 bits, write bit set, address in range.
  task automatic model_frame(input logic [31:0] v, input int n);
    logic [15:0] f;
    f = v[15:0];
    if (n == 16 && f[15] && f[14:8] < 7'd5)
      exp_q[f[14:8]] = f[7:0];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) exp_q[i] = 8'h00;
  endtask

  task automatic send_bits(input logic [31:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      copi = v[i];
      wclk(H);
      sclk = 1'b1;
      wclk(H);
      sclk = 1'b0;
    end
  endtask

  // Leaves ncs high exactly at the start of the returned cycle.
  task automatic spi_frame(input logic [31:0] v, input int n);
    ncs = 1'b0;
    wclk(H);
    send_bits(v, n - 1, 0);
    wclk(H);
    ncs = 1'b1;
  endtask

  task automatic do_frame(input logic [31:0] v, input int n);
    spi_frame(v, n);
    model_frame(v, n);
    wclk(GAP);
  endtask

  initial begin
    logic [31:0] v;
    int          n;

    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    model_reset();
    wclk(3);
    rst_n = 1'b1;
    wclk(2);
    check_all("reset");

    // single write, exact commit latency
    spi_frame(32'h80F0, 16);
    wclk(LAT - 1);
    check("lat_early", o0, 8'h00);
    wclk(1);
    check("lat_hit", o0, 8'hF0);
    model_frame(32'h80F0, 16);
    wclk(GAP - LAT);
    check_all("t1");

    // back-to-back at minimum gap
    do_frame(32'h8480, 16);
    do_frame(32'h8201, 16);
    check("t2_duty", o4, 8'h80);
    check("t2_pwmlo", o2, 8'h01);
    check_all("t2");

    // read frame and out-of-range address
    do_frame(32'h00AA, 16);
    do_frame(32'h8555, 16);
    check_all("t3");

    // short and long frames
    do_frame(32'h40AA, 15);
    do_frame((32'h8155 << 1) | 32'h1, 17);
    check("t4_outhi", o1, 8'h00);
    check_all("t4");

    // reset mid-frame, then finish clocking with ncs still low
    v = 32'h84AB;
    ncs = 1'b0;
    wclk(H);
    send_bits(v, 15, 8);
    rst_n = 1'b0;
    model_reset();
    wclk(3);
    check_all("t5_inrst");
    rst_n = 1'b1;
    wclk(2);
    send_bits(v, 7, 0);
    wclk(H);
    ncs = 1'b1;
    wclk(GAP + 2);
    check_all("t5");

    // program all, then sclk noise while deselected
    do_frame(32'h80FF, 16);
    do_frame(32'h8100, 16);
    do_frame(32'h82FF, 16);
    do_frame(32'h8300, 16);
    do_frame(32'h84FF, 16);
    check_all("t6_prog");
    for (int i = 0; i < 20; i++) begin
      copi = 1'($urandom);
      wclk(H);
      sclk = 1'b1;
      wclk(H);
      sclk = 1'b0;
    end
    wclk(GAP);
    check_all("t6_hold");

    // randomised frames
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      v = $urandom;
      v[15:8] = {($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7))};
      if (n == 17) v = (v << 1) | 32'($urandom_range(0, 1));
      do_frame(v, n);
      check_all($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
